// File: rtl/tick_monitor_pkg.sv
// Shared types and helpers for the tick monitor.
// State encoding and saturation constant helper.
package tick_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } tm_state_t;

    function automatic logic [31:0] TM_CNT_SAT(input int w);
        if (w >= 32) return '1;
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/tick_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear.
// inc together with clr restarts the count at one.
module sat_counter
    import tick_monitor_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] MAX = W'(TM_CNT_SAT(W));

    logic [W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= '0;
        end else if (inc && clr) begin
            r_q <= W'(1);
        end else if (clr) begin
            r_q <= '0;
        end else if (inc && (r_q != MAX)) begin
            r_q <= r_q + W'(1);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/tick_monitor.sv
// Tick period checker: acquires lock on PERIOD, flags early/late ticks.
// Optional min/max period statistics under TICK_MONITOR_STATS_EN.
module tick_monitor
    import tick_monitor_pkg::*;
#(
    parameter int PERIOD   = 3,
    parameter int LOCK_CNT = 4,
    parameter int CNT_W    = 8,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick_i,
    input  logic             clear,
    output logic             locked,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             err_early,
    output logic             err_late,
    output logic [ERR_W-1:0] err_cnt,
    output logic [CNT_W-1:0] period_min,
    output logic [CNT_W-1:0] period_max
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TM_CNT_SAT(CNT_W));
    localparam logic [CNT_W-1:0] PER     = CNT_W'(PERIOD);
    localparam int               MW      = $clog2(LOCK_CNT + 1);
    localparam logic [MW-1:0]    MLAST   = MW'(LOCK_CNT - 1);

    tm_state_t        r_state;
    tm_state_t        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_locked;
    logic [CNT_W-1:0] r_period;
    logic             r_pv;
    logic             r_early;
    logic             r_late;
    logic [MW-1:0]    w_match;
    logic             w_hit;
    logic             w_pv;
    logic             w_early;
    logic             w_late;
    logic             w_match_inc;
    logic             w_match_clr;

    assign w_hit = tick_i && (r_cnt == PER);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (tick_i) w_state_nxt = ACQ;
            end
            ACQ: begin
                if (w_hit && (w_match == MLAST)) w_state_nxt = LOCKED;
            end
            LOCKED: begin
                if (tick_i && !w_hit) w_state_nxt = ACQ;
                else if (!tick_i && (r_cnt == PER)) w_state_nxt = ACQ;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // In IDLE the counter idles at zero; elsewhere it runs and saturates.
    always_comb begin
        w_cnt_nxt   = r_cnt;
        w_pv        = 1'b0;
        w_early     = 1'b0;
        w_late      = 1'b0;
        w_match_inc = 1'b0;
        w_match_clr = 1'b0;
        if (tick_i) begin
            w_cnt_nxt = CNT_W'(1);
        end else if (r_state == IDLE) begin
            w_cnt_nxt = '0;
        end else if (r_cnt != CNT_MAX) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end
        unique case (1'b1)
            (r_state == ACQ): begin
                w_pv        = tick_i;
                w_match_inc = w_hit && (w_match != MLAST);
                w_match_clr = tick_i && !(w_hit && (w_match != MLAST));
            end
            (r_state == LOCKED): begin
                w_pv        = tick_i;
                w_early     = tick_i && !w_hit;
                w_late      = !tick_i && (r_cnt == PER);
                w_match_clr = w_early || w_late;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_locked <= 1'b0;
            r_period <= '0;
            r_pv     <= 1'b0;
            r_early  <= 1'b0;
            r_late   <= 1'b0;
        end else begin
            r_locked <= (w_state_nxt == LOCKED);
            r_pv     <= w_pv;
            r_early  <= w_early;
            r_late   <= w_late;
            if (w_pv) r_period <= r_cnt;
        end
    end

    sat_counter #(.W(MW)) u_match (
        .clk   (clk),
        .reset (reset),
        .inc   (w_match_inc),
        .clr   (w_match_clr),
        .q     (w_match)
    );

    sat_counter #(.W(ERR_W)) u_err (
        .clk   (clk),
        .reset (reset),
        .inc   (w_early || w_late),
        .clr   (clear),
        .q     (err_cnt)
    );

    assign locked       = r_locked;
    assign period       = r_period;
    assign period_valid = r_pv;
    assign err_early    = r_early;
    assign err_late     = r_late;

`ifdef TICK_MONITOR_STATS_EN
    logic [CNT_W-1:0] r_min;
    logic [CNT_W-1:0] r_max;
    logic [CNT_W-1:0] w_min_base;
    logic [CNT_W-1:0] w_max_base;

    // A clear in the same cycle as an update folds the new period into fresh values.
    always_comb begin
        w_min_base = clear ? CNT_MAX : r_min;
        w_max_base = clear ? '0 : r_max;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_min <= CNT_MAX;
            r_max <= '0;
        end else begin
            r_min <= (w_pv && (r_cnt < w_min_base)) ? r_cnt : w_min_base;
            r_max <= (w_pv && (r_cnt > w_max_base)) ? r_cnt : w_max_base;
        end
    end

    assign period_min = r_min;
    assign period_max = r_max;
`else
    assign period_min = CNT_MAX;
    assign period_max = '0;
`endif

endmodule

// File: tb/tb_tick_monitor.sv
// Scenario bench for tick_monitor: lock, early, late, saturation, stats.
// Expected periods are queued as ticks are driven and popped on period_valid.
module tb_tick_monitor;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick_i = 1'b0;
    logic       clear = 1'b0;

    logic       locked, pv, early, late;
    logic [7:0] period, err_cnt, pmin, pmax;
    logic       locked2, pv2, early2, late2;
    logic [7:0] period2, pmin2, pmax2;
    logic [1:0] err2;

    int total = 0;
    int bad = 0;
    int q[$];
    int exp_p;

    always #5 clk = ~clk;

    tick_monitor #(.PERIOD(3), .LOCK_CNT(4), .CNT_W(8), .ERR_W(8)) u_dut (
        .clk          (clk),
        .reset        (reset),
        .tick_i       (tick_i),
        .clear        (clear),
        .locked       (locked),
        .period       (period),
        .period_valid (pv),
        .err_early    (early),
        .err_late     (late),
        .err_cnt      (err_cnt),
        .period_min   (pmin),
        .period_max   (pmax)
    );

    tick_monitor #(.PERIOD(3), .LOCK_CNT(4), .CNT_W(8), .ERR_W(2)) u_dut2 (
        .clk          (clk),
        .reset        (reset),
        .tick_i       (tick_i),
        .clear        (clear),
        .locked       (locked2),
        .period       (period2),
        .period_valid (pv2),
        .err_early    (early2),
        .err_late     (late2),
        .err_cnt      (err2),
        .period_min   (pmin2),
        .period_max   (pmax2)
    );

    always @(negedge clk) begin
        if (pv === 1'b1) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL pv_unexpected got period=%0d want no pulse", period);
            end else begin
                exp_p = q.pop_front();
                if (period !== 8'(exp_p)) begin
                    bad++;
                    $display("FAIL period got=%0d want=%0d", period, exp_p);
                end
            end
        end
    end

    task automatic cyc(input logic t);
        tick_i = t;
        @(posedge clk);
        #1;
        tick_i = 1'b0;
    endtask

    task automatic gap(input int n);
        for (int i = 1; i < n; i++) cyc(1'b0);
        q.push_back(n);
        cyc(1'b1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(1'b0);
        cyc(1'b0);
        reset = 1'b0;
    endtask

    task automatic lock_up();
        cyc(1'b1);
        repeat (4) gap(3);
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({locked, period, pv, early, late, err_cnt, pmin, pmax} !==
            {1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'hFF, 8'd0}) begin
            bad++;
            $display("FAIL reset_vals got=%h want=%h",
                {locked, period, pv, early, late, err_cnt, pmin, pmax},
                {1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'hFF, 8'd0});
        end
    endtask

    task automatic test_lock();
        do_reset();
        cyc(1'b1);
        repeat (3) gap(3);
        total++;
        if (locked !== 1'b0) begin
            bad++;
            $display("FAIL lock_early got=%b want=0", locked);
        end
        gap(3);
        total++;
        if (locked !== 1'b1) begin
            bad++;
            $display("FAIL lock_set got=%b want=1", locked);
        end
        total++;
        if (err_cnt !== 8'd0) begin
            bad++;
            $display("FAIL lock_err got=%0d want=0", err_cnt);
        end
    endtask

    task automatic test_early();
        q.push_back(2);
        cyc(1'b0);
        cyc(1'b1);
        total++;
        if ({early, late, locked} !== 3'b100) begin
            bad++;
            $display("FAIL early_pulse got=%b want=100", {early, late, locked});
        end
        total++;
        if (err_cnt !== 8'd1) begin
            bad++;
            $display("FAIL early_cnt got=%0d want=1", err_cnt);
        end
        cyc(1'b0);
        total++;
        if (early !== 1'b0) begin
            bad++;
            $display("FAIL early_width got=%b want=0", early);
        end
        cyc(1'b0);
        q.push_back(3);
        cyc(1'b1);
        repeat (3) gap(3);
        total++;
        if (locked !== 1'b1) begin
            bad++;
            $display("FAIL early_relock got=%b want=1", locked);
        end
    endtask

    task automatic test_late();
        do_reset();
        lock_up();
        repeat (3) cyc(1'b0);
        total++;
        if ({late, early, locked} !== 3'b100) begin
            bad++;
            $display("FAIL late_pulse got=%b want=100", {late, early, locked});
        end
        cyc(1'b0);
        total++;
        if (late !== 1'b0) begin
            bad++;
            $display("FAIL late_width got=%b want=0", late);
        end
        cyc(1'b0);
        q.push_back(6);
        cyc(1'b1);
        total++;
        if (err_cnt !== 8'd1) begin
            bad++;
            $display("FAIL late_cnt got=%0d want=1", err_cnt);
        end
    endtask

    task automatic test_err_sat();
        do_reset();
        cyc(1'b1);
        for (int i = 0; i < 5; i++) begin
            repeat (4) gap(3);
            q.push_back(2);
            cyc(1'b0);
            cyc(1'b1);
        end
        total++;
        if (err_cnt !== 8'd5) begin
            bad++;
            $display("FAIL sat_wide got=%0d want=5", err_cnt);
        end
        total++;
        if (err2 !== 2'd3) begin
            bad++;
            $display("FAIL sat_narrow got=%0d want=3", err2);
        end
        repeat (4) gap(3);
        q.push_back(2);
        cyc(1'b0);
        clear = 1'b1;
        cyc(1'b1);
        clear = 1'b0;
        total++;
        if ({err_cnt, err2} !== {8'd1, 2'd1}) begin
            bad++;
            $display("FAIL clr_vs_err got=%0d/%0d want=1/1", err_cnt, err2);
        end
        clear = 1'b1;
        cyc(1'b0);
        clear = 1'b0;
        total++;
        if (err_cnt !== 8'd0) begin
            bad++;
            $display("FAIL clr_only got=%0d want=0", err_cnt);
        end
    endtask

    task automatic test_long();
        do_reset();
        cyc(1'b1);
        repeat (300) cyc(1'b0);
        q.push_back(255);
        cyc(1'b1);
        total++;
        if ({period, locked} !== {8'd255, 1'b0}) begin
            bad++;
            $display("FAIL long_gap got=%0d/%b want=255/0", period, locked);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        lock_up();
        total++;
        if (locked !== 1'b1) begin
            bad++;
            $display("FAIL mid_pre got=%b want=1", locked);
        end
        reset = 1'b1;
        cyc(1'b0);
        total++;
        if ({locked, period, pv, early, late, err_cnt, pmin, pmax} !==
            {1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'hFF, 8'd0}) begin
            bad++;
            $display("FAIL mid_reset got=%h want=%h",
                {locked, period, pv, early, late, err_cnt, pmin, pmax},
                {1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'hFF, 8'd0});
        end
        reset = 1'b0;
        cyc(1'b1);
        repeat (3) gap(3);
        total++;
        if (locked !== 1'b0) begin
            bad++;
            $display("FAIL mid_fresh got=%b want=0", locked);
        end
        gap(3);
        total++;
        if (locked !== 1'b1) begin
            bad++;
            $display("FAIL mid_relock got=%b want=1", locked);
        end
    endtask

    task automatic test_stats();
        logic [7:0] emin;
        logic [7:0] emax;
        do_reset();
        cyc(1'b1);
        gap(3);
        gap(5);
        gap(2);
`ifdef TICK_MONITOR_STATS_EN
        emin = 8'd2;
        emax = 8'd5;
`else
        emin = 8'hFF;
        emax = 8'd0;
`endif
        total++;
        if ({pmin, pmax} !== {emin, emax}) begin
            bad++;
            $display("FAIL stats got=%0d/%0d want=%0d/%0d", pmin, pmax, emin, emax);
        end
        clear = 1'b1;
        cyc(1'b0);
        clear = 1'b0;
        total++;
        if ({pmin, pmax} !== {8'hFF, 8'd0}) begin
            bad++;
            $display("FAIL stats_clr got=%0d/%0d want=255/0", pmin, pmax);
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_early();
        test_late();
        test_err_sat();
        test_long();
        test_reset_mid();
        test_stats();
        repeat (2) cyc(1'b0);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL queue_left got=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tick_monitor.md
Name: tick_monitor

Overview:
- Receiving end of a periodic single-cycle tick strobe, such as the one produced by the team's 3-cycle tick FSM.
- Measures the clock count between successive ticks and declares lock after LOCK_CNT consecutive periods equal to PERIOD.
- Once locked, flags early or missing ticks and keeps a saturating error count.
- Sits beside tick generators as an in-design checker and health indicator.

Parameters:
- PERIOD, 3, expected tick period in clk cycles (legal range 2 .. 2^CNT_W-1)
- LOCK_CNT, 4, consecutive matching periods required to lock (>=1)
- CNT_W, 8, width of the period counter and the period output
- ERR_W, 8, width of the saturating error counter

Ports:
- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high
- tick_i  input  1  tick strobe under test, sampled every clk
- clear  input  1  synchronous clear of err_cnt and statistics
- locked  output  1  high while the FSM is in LOCKED
- period  output  CNT_W  last measured tick-to-tick period
- period_valid  output  1  one-cycle pulse when period updates
- err_early  output  1  one-cycle pulse: tick arrived before PERIOD while locked
- err_late  output  1  one-cycle pulse: expected tick absent while locked
- err_cnt  output  ERR_W  saturating count of early plus late errors
- period_min  output  CNT_W  smallest measured period (see optional feature)
- period_max  output  CNT_W  largest measured period (see optional feature)

Behaviour:
- Reset values:
  - state=IDLE, cnt=0, match=0, locked=0, period=0
  - period_valid=0, err_early=0, err_late=0, err_cnt=0
  - period_min = all ones, period_max = 0
- cnt: on a tick cycle, cnt<=1; otherwise cnt<=cnt+1, saturating at 2^CNT_W-1. For ticks P cycles apart, cnt==P on the second tick's cycle.
- All outputs are registered; each output reflects the event one cycle after the causing tick_i sample.
- IDLE:
  - Non-tick cycles: cnt held at 0.
  - First tick: go to ACQ, cnt<=1. No period_valid (no reference edge yet).
- ACQ:
  - Any tick: period<=cnt and period_valid pulses.
  - Tick with cnt==PERIOD: match<=match+1. If match+1==LOCK_CNT, go to LOCKED and match<=0.
  - Tick with cnt!=PERIOD: match<=0, stay in ACQ.
  - No error pulses are raised in ACQ.
- LOCKED:
  - Tick with cnt==PERIOD: period/period_valid update, stay LOCKED.
  - Tick with cnt<PERIOD: period/period_valid update, err_early pulses, go to ACQ, match<=0.
  - No tick on a cycle with cnt==PERIOD: err_late pulses, go to ACQ, match<=0. cnt keeps counting, so the next tick yields the true long period.
- locked equals (state==LOCKED), registered.
- err_cnt: +1 per err_early or err_late, saturating at 2^ERR_W-1. Both cannot fire in the same cycle.
- clear and an error in the same cycle: the error wins, err_cnt<=1.
- clear does not affect the state, cnt, match or locked.
- Reset mid-operation: all state returns to reset values; re-lock requires a fresh first tick plus LOCK_CNT matching periods.
- Worked example (PERIOD=3, LOCK_CNT=4): ticks at cycles 0,3,6,9,12 give match complete at cycle 12; locked=1 from cycle 13.

Optional Feature:
- Macro: TICK_MONITOR_STATS_EN.
- Defined:
  - period_min and period_max update on every period_valid: min<=min(min,period), max<=max(max,period).
  - clear returns them to all ones and 0.
  - Update and clear in the same cycle: the update applies against the cleared values.
- Undefined: the ports remain, driven constant all ones and 0; no stats registers are synthesised.

Decomposition:
- Package tick_monitor_pkg:
  - typedef enum logic [1:0] {IDLE, ACQ, LOCKED} tm_state_t
  - constant TM_CNT_SAT helper function returning the all-ones value for a given width
- Sub-module sat_counter (parameter W; inputs inc, clr; output q) serves err_cnt and the match counter.
- The period counter stays inline because it has a load-to-1 behaviour.

Test Plan:
- Ticks every 3 cycles from cycle 0 -> period_valid with period=3 from cycle 4; locked=1 at cycle 13; err_cnt=0.
- Locked, then a tick 2 cycles after the previous one -> err_early pulse, period=2, locked=0 next cycle, err_cnt=1; re-lock after 4 more good periods.
- Locked, then a tick omitted -> err_late on the cycle after cnt==3 with no tick; next tick at +6 reports period=6; err_cnt=1.
- ERR_W=2 with 5 forced early errors -> err_cnt saturates at 3; clear coincident with an error -> err_cnt=1.
- No ticks for 300 cycles after one tick (CNT_W=8), then a tick -> period=255 (saturated); FSM stays in ACQ.
- Reset asserted while locked -> all outputs at reset values next cycle. With TICK_MONITOR_STATS_EN and periods 3,5,2 -> period_min=2, period_max=5.
